// File: rtl/snake_step_ctrl_if.sv
// snake_step_ctrl_if: shared x/y/read-enable port of the 15x15 snake world memory.
`default_nettype none

interface snake_step_ctrl_if;
   logic [4:0] x;
   logic [4:0] y;
   logic       read_en;
   logic [1:0] wdata;
   logic [1:0] rdata;

   modport master (output x, output y, output read_en, output wdata, input rdata);
   modport slave  (input x, input y, input read_en, input wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: per-tick game-step sequencer; moves the head, detects collisions,
// clears the tail or grows and places food. Sole writer of the world memory.
`default_nettype none

module snake_step_ctrl #(
   parameter int         MAX_LEN   = 32,
   parameter int         GRID      = 15,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,        // active-low, asynchronous
   input  logic              tick,
   input  logic [1:0]        dir_in,
   snake_step_ctrl_if.master mem,
   output logic              busy,
   output logic              game_over,
   output logic [7:0]        score,
   output logic [7:0]        length
);

   localparam int                PW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]        LEN_MAX = 8'(MAX_LEN);
   localparam logic signed [5:0] GRID_S  = 6'(GRID);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WR_HEAD, S_CLR_TAIL, S_FOOD_PROBE, S_FOOD_WR, S_DEAD
   } state_t;

   state_t            state, state_nx;
   logic [1:0]        dir;
   logic [4:0]        nh_x, nh_y;
   logic              grow;
   logic [7:0]        lfsr;
   logic [9:0]        body [MAX_LEN];
   logic [PW-1:0]     head_ptr, tail_ptr;

   logic [1:0]        dir_eff;
   logic signed [5:0] hx, hy, nx, ny;
   logic              step_ok;
   logic [PW-1:0]     head_ptr_inc, tail_ptr_inc;
   logic [4:0]        cand_x, cand_y;
   logic [7:0]        lfsr_step;

   always_comb begin
      // A request for the exact opposite direction would fold the snake onto itself.
      dir_eff = (dir_in == (dir ^ 2'b10)) ? dir : dir_in;
      hx = $signed({1'b0, body[head_ptr][9:5]});
      hy = $signed({1'b0, body[head_ptr][4:0]});
      nx = hx;
      ny = hy;
      case (dir_eff)
         2'b00:   ny = hy - 6'sd1;
         2'b01:   nx = hx + 6'sd1;
         2'b10:   ny = hy + 6'sd1;
         default: nx = hx - 6'sd1;
      endcase
      step_ok = (nx >= 6'sd1) && (nx <= GRID_S) && (ny >= 6'sd1) && (ny <= GRID_S);

      head_ptr_inc = (head_ptr == PW'(MAX_LEN - 1)) ? '0 : head_ptr + PW'(1);
      tail_ptr_inc = (tail_ptr == PW'(MAX_LEN - 1)) ? '0 : tail_ptr + PW'(1);

      cand_x = (lfsr[3:0] == 4'd15) ? 5'd1 : {1'b0, lfsr[3:0]} + 5'd1;
      cand_y = (lfsr[7:4] == 4'd15) ? 5'd1 : {1'b0, lfsr[7:4]} + 5'd1;
      // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
      lfsr_step = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      mem.x       = 5'd1;
      mem.y       = 5'd1;
      mem.read_en = 1'b1;
      mem.wdata   = 2'b00;
      case (state)
         S_IDLE: begin
            if (tick) state_nx = step_ok ? S_READ : S_DEAD;
         end
         S_READ: begin
            mem.x    = nh_x;
            mem.y    = nh_y;
            state_nx = (mem.rdata == 2'b10) ? S_DEAD : S_WR_HEAD;
         end
         S_WR_HEAD: begin
            mem.x       = nh_x;
            mem.y       = nh_y;
            mem.read_en = 1'b0;
            mem.wdata   = 2'b10;
            state_nx    = (grow && (length < LEN_MAX)) ? S_FOOD_PROBE : S_CLR_TAIL;
         end
         S_CLR_TAIL: begin
            mem.x       = body[tail_ptr][9:5];
            mem.y       = body[tail_ptr][4:0];
            mem.read_en = 1'b0;
            state_nx    = grow ? S_FOOD_PROBE : S_IDLE;
         end
         S_FOOD_PROBE: begin
            mem.x = cand_x;
            mem.y = cand_y;
            if (mem.rdata == 2'b00) state_nx = S_FOOD_WR;
         end
         S_FOOD_WR: begin
            mem.x       = cand_x;
            mem.y       = cand_y;
            mem.read_en = 1'b0;
            mem.wdata   = 2'b01;
            state_nx    = S_IDLE;
         end
         default: state_nx = S_DEAD;
      endcase
   end

   assign busy      = (state != S_IDLE) && (state != S_DEAD);
   assign game_over = (state == S_DEAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir      <= 2'b01;
         nh_x     <= 5'd0;
         nh_y     <= 5'd0;
         grow     <= 1'b0;
         lfsr     <= LFSR_SEED;
         score    <= 8'd0;
         length   <= 8'd3;
         head_ptr <= PW'(2);
         tail_ptr <= '0;
         for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
         body[0] <= {5'd1, 5'd1};
         body[1] <= {5'd2, 5'd1};
         body[2] <= {5'd3, 5'd1};
      end else begin
         case (state)
            S_IDLE: begin
               if (tick) begin
                  dir  <= dir_eff;
                  nh_x <= nx[4:0];
                  nh_y <= ny[4:0];
               end
            end
            S_READ: grow <= (mem.rdata == 2'b01);
            S_WR_HEAD: begin
               body[head_ptr_inc] <= {nh_x, nh_y};
               head_ptr           <= head_ptr_inc;
               if (grow) begin
                  if (score != 8'hFF)    score  <= score + 8'd1;
                  if (length < LEN_MAX)  length <= length + 8'd1;
               end
            end
            S_CLR_TAIL:   tail_ptr <= tail_ptr_inc;
            S_FOOD_PROBE: if (mem.rdata != 2'b00) lfsr <= lfsr_step;
            S_FOOD_WR:    lfsr <= lfsr_step;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed scenarios against a world-memory model; expected memory
// writes are queued by the stimulus and checked by a decoupled write monitor.
`default_nettype none

module tb_snake_step_ctrl;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       tick   = 1'b0;
   logic [1:0] dir_in = 2'b01;
   logic       busy, game_over;
   logic [7:0] score, length;

   snake_step_ctrl_if mif ();

   snake_step_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .dir_in    (dir_in),
      .mem       (mif),
      .busy      (busy),
      .game_over (game_over),
      .score     (score),
      .length    (length)
   );

   always #5 clk = ~clk;

   // World memory model, reset together with the DUT; optional single-cell preload.
   logic [1:0] world [16][16];
   logic       pre_en = 1'b0;
   logic [3:0] pre_x  = 4'd0;
   logic [3:0] pre_y  = 4'd0;
   logic [1:0] pre_v  = 2'b00;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) world[i][j] <= 2'b00;
         world[1][1] <= 2'b10;
         world[2][1] <= 2'b10;
         world[3][1] <= 2'b10;
         if (pre_en) world[pre_x][pre_y] <= pre_v;
      end else if (!mif.read_en && mif.x < 5'd16 && mif.y < 5'd16) begin
         world[mif.x[3:0]][mif.y[3:0]] <= mif.wdata;
      end
   end

   assign mif.rdata = (mif.x < 5'd16 && mif.y < 5'd16) ? world[mif.x[3:0]][mif.y[3:0]] : 2'b00;

   logic [11:0] exp_q [$];
   int checks     = 0;
   int failures   = 0;
   int busy_total = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_wr(input int x, input int y, input int d);
      exp_q.push_back({5'(x), 5'(y), 2'(d)});
   endtask

   task automatic do_reset(input bit en, input int px, input int py, input int pv);
      pre_en = en;
      pre_x  = 4'(px);
      pre_y  = 4'(py);
      pre_v  = 2'(pv);
      tick   = 1'b0;
      dir_in = 2'b01;
      @(posedge clk); #1;
      rst = 1'b0;
      #10;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_tick(input logic [1:0] d);
      tick   = 1'b1;
      dir_in = d;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   task automatic run_basic(input string tag);
      int b0;
      b0 = busy_total;
      push_wr(4, 1, 2);
      push_wr(1, 1, 0);
      do_tick(2'b01);
      check({tag, "_c1_read_en"}, int'(mif.read_en), 1);
      @(posedge clk); #1;
      check({tag, "_c2_head_wr"}, int'({mif.read_en, mif.x, mif.y, mif.wdata}),
            int'({1'b0, 5'd4, 5'd1, 2'b10}));
      @(posedge clk); #1;
      check({tag, "_c3_tail_clr"}, int'({mif.read_en, mif.x, mif.y, mif.wdata}),
            int'({1'b0, 5'd1, 5'd1, 2'b00}));
      wait_idle();
      check({tag, "_busy_cycles"}, busy_total - b0, 3);
      check({tag, "_length"}, int'(length), 3);
      check({tag, "_score"}, int'(score), 0);
      check({tag, "_sb_drained"}, exp_q.size(), 0);
      check({tag, "_world_head"}, int'(world[4][1]), 2);
      check({tag, "_world_tail"}, int'(world[1][1]), 0);
   endtask

   initial begin
      logic [11:0] got, e;
      int b0;

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               if (busy) busy_total++;
               if (!mif.read_en) begin
                  got = {mif.x, mif.y, mif.wdata};
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL write_unexpected: got x=%0d y=%0d d=%0d expected none",
                              got[11:7], got[6:2], got[1:0]);
                  end else begin
                     e = exp_q.pop_front();
                     if (got != e) begin
                        failures++;
                        $display("FAIL write_match: got x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d",
                                 got[11:7], got[6:2], got[1:0], e[11:7], e[6:2], e[1:0]);
                     end
                  end
                  if (mif.wdata == 2'b01 && mif.x < 5'd16 && mif.y < 5'd16)
                     check("food_target_empty", int'(world[mif.x[3:0]][mif.y[3:0]]), 0);
               end
            end
         end
      join_none

      // Scenario 1: reset state and a plain step to the right.
      do_reset(1'b0, 0, 0, 0);
      check("rst_length", int'(length), 3);
      check("rst_score", int'(score), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_mem_port", int'({mif.read_en, mif.x, mif.y, mif.wdata}),
            int'({1'b1, 5'd1, 5'd1, 2'b00}));
      run_basic("s1");

      // Scenario 2: reversal ignored, then turn down.
      do_reset(1'b0, 0, 0, 0);
      push_wr(4, 1, 2);
      push_wr(1, 1, 0);
      do_tick(2'b11);
      wait_idle();
      push_wr(4, 2, 2);
      push_wr(2, 1, 0);
      do_tick(2'b10);
      wait_idle();
      check("s2_sb_drained", exp_q.size(), 0);
      check("s2_world_turn", int'(world[4][2]), 2);

      // Scenario 3: wall collision moving up from row 1.
      do_reset(1'b0, 0, 0, 0);
      b0 = busy_total;
      do_tick(2'b00);
      check("s3_game_over_next", int'(game_over), 1);
      do_tick(2'b01);
      @(posedge clk); #1;
      do_tick(2'b10);
      repeat (3) @(posedge clk);
      #1;
      check("s3_busy_never", busy_total - b0, 0);
      check("s3_game_over_sticky", int'(game_over), 1);
      check("s3_length", int'(length), 3);

      // Scenario 4: eat food at (4,1); seed A5 places new food at (6,11).
      do_reset(1'b1, 4, 1, 1);
      b0 = busy_total;
      push_wr(4, 1, 2);
      push_wr(6, 11, 1);
      do_tick(2'b01);
      wait_idle();
      check("s4_busy_cycles", busy_total - b0, 4);
      check("s4_length", int'(length), 4);
      check("s4_score", int'(score), 1);
      check("s4_sb_drained", exp_q.size(), 0);
      for (int i = 1; i <= 4; i++) check("s4_snake_cell", int'(world[i][1]), 2);
      check("s4_food_cell", int'(world[6][11]), 1);

      // Scenario 5: body collision discovered in READ.
      do_reset(1'b1, 4, 1, 2);
      do_tick(2'b01);
      check("s5_game_over_read", int'(game_over), 0);
      @(posedge clk); #1;
      check("s5_game_over_after", int'(game_over), 1);
      check("s5_busy", int'(busy), 0);
      check("s5_length", int'(length), 3);
      check("s5_score", int'(score), 0);
      repeat (2) @(posedge clk);
      #1;
      check("s5_sb_drained", exp_q.size(), 0);

      // Scenario 6: asynchronous reset during WR_HEAD of a growing step.
      do_reset(1'b1, 4, 1, 1);
      do_tick(2'b01);
      @(posedge clk); #1;
      check("s6_in_wr_head", int'(mif.read_en), 0);
      pre_en = 1'b0;
      rst    = 1'b0;
      #1;
      check("s6_rst_length", int'(length), 3);
      check("s6_rst_busy", int'(busy), 0);
      check("s6_rst_mem_port", int'({mif.read_en, mif.x, mif.y, mif.wdata}),
            int'({1'b1, 5'd1, 5'd1, 2'b00}));
      check("s6_rst_score", int'(score), 0);
      @(posedge clk); #4;
      rst = 1'b1;
      @(posedge clk); #1;
      run_basic("s6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
